// File: rtl/smooth_arbiter.sv
// ---------------------------------------------------------------------------
// smooth_arbiter
//   Shared moving-average engine. Per-channel sample requests are
//   round-robin arbitrated into a single running-sum datapath; every channel
//   owns a 2^LOG2_DEPTH-entry circular window and a running sum. One
//   averaged, channel-tagged result is produced per accepted sample.
//
//   Transaction: IDLE (grant + latch sample) -> UPD (ack, update window)
//                -> OUT (result valid) -> IDLE. One sample per 3 cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (low = reset)
//   req        per-channel level request
//   data       channel c sample at [c*W +: W], stable while req[c] is high
//   flush      synchronous clear of all windows/sums/pointers/counts
//   ack        one-hot, one-cycle pulse: sample of that channel accepted
//   out_valid  one-cycle pulse: out_ch/out_avg/out_full carry a new result
//   out_ch     channel of the result
//   out_avg    window sum >> LOG2_DEPTH (empty slots count as zero)
//   out_full   window of out_ch holds DEPTH real samples
// ---------------------------------------------------------------------------
module smooth_arbiter #(
    parameter int NCH        = 4,
    parameter int W          = 12,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*W-1:0]        data,
    input  logic                    flush,
    output logic [NCH-1:0]          ack,
    output logic                    out_valid,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic [W-1:0]            out_avg,
    output logic                    out_full
);

    localparam int CHW   = $clog2(NCH);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = W + LOG2_DEPTH;   // sum of DEPTH W-bit samples fits
    localparam int CW    = LOG2_DEPTH + 1;   // count 0..DEPTH

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Global control state
    state_t           state_q, state_d;
    logic [CHW-1:0]   last_q, last_d;
    logic [CHW-1:0]   g_q, g_d;
    logic [W-1:0]     s_q, s_d;

    // Registered outputs
    logic [NCH-1:0]   ack_q, ack_d;
    logic             out_valid_q, out_valid_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;
    logic [W-1:0]     out_avg_q, out_avg_d;
    logic             out_full_q, out_full_d;

    // Per-channel window state
    logic [W-1:0]          buf_q [NCH][DEPTH];
    logic [W-1:0]          buf_d [NCH][DEPTH];
    logic [LOG2_DEPTH-1:0] ptr_q [NCH];
    logic [LOG2_DEPTH-1:0] ptr_d [NCH];
    logic [SW-1:0]         sum_q [NCH];
    logic [SW-1:0]         sum_d [NCH];
    logic [CW-1:0]         cnt_q [NCH];
    logic [CW-1:0]         cnt_d [NCH];

    // Unpack the flat sample bus into per-channel lanes
    logic [W-1:0] data_ch [NCH];
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            assign data_ch[gi] = data[gi*W +: W];
        end
    endgenerate

    // Round-robin pick: search last+1, last+2, ... wrapping, ending at last
    logic           pick_found;
    logic [CHW-1:0] pick;
    logic [CHW-1:0] scan_idx;

    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan_idx = CHW'((int'(last_q) + k) % NCH);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    // Window update terms for the latched grant
    logic [W-1:0]  old_sample;
    logic [SW-1:0] sum_new;
    logic [CW-1:0] cnt_new;

    always_comb begin
        old_sample = buf_q[g_q][ptr_q[g_q]];
        sum_new    = sum_q[g_q] - {{LOG2_DEPTH{1'b0}}, old_sample}
                                + {{LOG2_DEPTH{1'b0}}, s_q};
        cnt_new    = (cnt_q[g_q] == CW'(DEPTH)) ? cnt_q[g_q] : cnt_q[g_q] + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        g_d         = g_q;
        s_d         = s_q;
        ack_d       = '0;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_avg_d   = out_avg_q;
        out_full_d  = out_full_q;
        buf_d       = buf_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;

        if (flush) begin
            // Abort any in-flight transaction; the arbitration pointer survives
            state_d    = S_IDLE;
            out_ch_d   = '0;
            out_avg_d  = '0;
            out_full_d = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                ptr_d[c] = '0;
                sum_d[c] = '0;
                cnt_d[c] = '0;
                for (int e = 0; e < DEPTH; e++) begin
                    buf_d[c][e] = '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        g_d     = pick;
                        s_d     = data_ch[pick];
                        last_d  = pick;
                        ack_d   = {{(NCH-1){1'b0}}, 1'b1} << pick;
                        state_d = S_UPD;
                    end
                end
                S_UPD: begin
                    buf_d[g_q][ptr_q[g_q]] = s_q;
                    ptr_d[g_q]  = ptr_q[g_q] + 1'b1;    // natural wrap at DEPTH
                    sum_d[g_q]  = sum_new;
                    cnt_d[g_q]  = cnt_new;
                    // Result is built from the post-update window so it is
                    // ready as a registered output during OUT
                    out_valid_d = 1'b1;
                    out_ch_d    = g_q;
                    out_avg_d   = sum_new[SW-1:LOG2_DEPTH];
                    out_full_d  = (cnt_new == CW'(DEPTH));
                    state_d     = S_OUT;
                end
                S_OUT: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_q      <= CHW'(NCH - 1);   // channel 0 wins the first grant
            g_q         <= '0;
            s_q         <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_avg_q   <= '0;
            out_full_q  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                ptr_q[c] <= '0;
                sum_q[c] <= '0;
                cnt_q[c] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    buf_q[c][e] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            g_q         <= g_d;
            s_q         <= s_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_avg_q   <= out_avg_d;
            out_full_q  <= out_full_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
        end
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_avg   = out_avg_q;
    assign out_full  = out_full_q;

endmodule
